// File: rtl/gray_step_monitor.sv
// gray_step_monitor: decodes sampled Gray values and checks each new sample is a single-bit +1 step
module gray_step_monitor #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     gray_in,
   input  logic             sample_en,
   input  logic             clear,
   output logic [N-1:0]     bin_out,
   output logic             bin_valid,
   output logic             step_ok,
   output logic             wrap,
   output logic             err_flag,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       state_out
);
   localparam logic [1:0] INIT  = 2'b00;
   localparam logic [1:0] TRACK = 2'b01;
   localparam logic [1:0] ERROR = 2'b10;
   logic [1:0]   state;
   logic [N-1:0] prev_gray, prev_bin, bin, next_bin;
   logic         one_bit, no_change, succ;
   assign state_out = state;
   // binary bit i is the XOR of all Gray bits at or above i; classify the step against the reference
   always_comb begin
      bin = '0;
      for (int i = 0; i < N; i++) bin[i] = ^(gray_in >> i);
      next_bin  = prev_bin + 1'b1;
      one_bit   = $onehot(gray_in ^ prev_gray);
      no_change = gray_in == prev_gray;
      succ      = one_bit && bin == next_bin;
   end
   // sampling FSM: INIT/ERROR take an unchecked reference, TRACK checks every new sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= INIT;
         prev_gray <= '0;
         prev_bin  <= '0;
         bin_out   <= '0;
         bin_valid <= 1'b0;
         step_ok   <= 1'b0;
         wrap      <= 1'b0;
         err_flag  <= 1'b0;
         err_count <= '0;
      end else begin
         step_ok <= 1'b0;
         wrap    <= 1'b0;
         if (clear) begin
            err_flag  <= 1'b0;
            err_count <= '0;
            bin_valid <= 1'b0;
            state     <= INIT;
         end else if (state == 2'b11) begin
            state <= INIT;
         end else if (sample_en) begin
            prev_gray <= gray_in;
            prev_bin  <= bin;
            bin_out   <= bin;
            bin_valid <= 1'b1;
            if (state != TRACK) begin
               state <= TRACK;
            end else if (succ) begin
               step_ok <= 1'b1;
               wrap    <= &prev_bin;
            end else if (!no_change) begin
               err_flag  <= 1'b1;
               err_count <= err_count + {{(CNT_W-1){1'b0}}, ~&err_count};
               state     <= ERROR;
            end
         end
      end
   end
endmodule
